// File: rtl/servo_pkg.sv
// Shared widths, default travel limits and FSM state type for the servo
// slew scheduler and its helpers.
package servo_pkg;

    localparam int US_W   = 12;
    localparam int CH_W   = 2;
    localparam int NUM_CH = 4;

    localparam int DEF_MIN_US    = 1000;
    localparam int DEF_MAX_US    = 2000;
    localparam int DEF_CENTER_US = 1500;

    typedef logic [US_W-1:0] us_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Saturate a requested pulse width into the legal servo travel window.
    function automatic us_t clamp_us(input us_t value, input us_t lo, input us_t hi);
        if (value < lo) return lo;
        if (value > hi) return hi;
        return value;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Free-running divider producing a one-cycle registered strobe every DIV
// clocks; the strobe is high in the cycle the count sits at DIV-1.
module tick_divider #(
    parameter int DIV = 12000
) (
    input  logic CLK,
    input  logic RST,
    output logic tick
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] count;

    // Count 0..DIV-1 and raise tick one cycle ahead so it aligns with DIV-1.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
            tick  <= 1'b0;
        end else begin
            if (count == CNT_W'(DIV - 1)) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
            tick <= (count == CNT_W'(DIV - 2));
        end
    end

endmodule

// File: rtl/servo_slew_scheduler.sv
// Time-multiplexed slew limiter for four servo channels. Each scheduler tick
// walks channels 0..3 through one shared step unit, moving every live command
// at most STEP_US toward its clamped target.
module servo_slew_scheduler
    import servo_pkg::*;
#(
    parameter int CLK_HZ    = 12000000,
    parameter int TICK_HZ   = 1000,
    parameter int STEP_US   = 10,
    parameter int MIN_US    = DEF_MIN_US,
    parameter int MAX_US    = DEF_MAX_US,
    parameter int CENTER_US = DEF_CENTER_US
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [US_W-1:0] wr_us,
    input  logic            hold,
    output logic [US_W-1:0] cmd0,
    output logic [US_W-1:0] cmd1,
    output logic [US_W-1:0] cmd2,
    output logic [US_W-1:0] cmd3,
    output logic [NUM_CH-1:0] settled,
    output logic            tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    localparam logic [US_W:0] STEP_W = (US_W + 1)'(STEP_US);
    localparam us_t           MIN_V  = US_W'(MIN_US);
    localparam us_t           MAX_V  = US_W'(MAX_US);
    localparam us_t           CTR_V  = US_W'(CENTER_US);

    state_t          state;
    logic [CH_W-1:0] ch;
    us_t             tgt [NUM_CH];
    us_t             cmd [NUM_CH];

    us_t             cur_sel;
    us_t             tgt_sel;
    logic [US_W:0]   diff;
    us_t             step_out;

    logic            wr_fire;
    us_t             tgt_nxt [NUM_CH];
    us_t             cmd_nxt [NUM_CH];
    logic [NUM_CH-1:0] settled_nxt;

    tick_divider #(
        .DIV (DIV)
    ) u_tick_divider (
        .CLK  (CLK),
        .RST  (RST),
        .tick (tick)
    );

    assign wr_fire = wr_valid && wr_ready;

    // Shared step unit: move the selected command toward its target, landing
    // exactly on the target when the remaining distance is within one step.
    always_comb begin
        cur_sel  = cmd[ch];
        tgt_sel  = tgt[ch];
        diff     = '0;
        step_out = cur_sel;
        if (cur_sel < tgt_sel) begin
            diff     = {1'b0, tgt_sel} - {1'b0, cur_sel};
            step_out = (diff <= STEP_W) ? tgt_sel
                                        : US_W'({1'b0, cur_sel} + STEP_W);
        end else if (cur_sel > tgt_sel) begin
            diff     = {1'b0, cur_sel} - {1'b0, tgt_sel};
            step_out = (diff <= STEP_W) ? tgt_sel
                                        : US_W'({1'b0, cur_sel} - STEP_W);
        end
    end

    // Next-state view of targets and commands so settled can be registered
    // in the same cycle either side of the comparison changes.
    always_comb begin
        // NOTE: whole-array defaults first keep every element driven on every path, so no latches appear.
        tgt_nxt = tgt;
        cmd_nxt = cmd;
        if (wr_fire) begin
            tgt_nxt[wr_ch] = clamp_us(wr_us, MIN_V, MAX_V);
        end
        if (state == SCAN) begin
            cmd_nxt[ch] = step_out;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            settled_nxt[k] = (cmd_nxt[k] == tgt_nxt[k]);
        end
    end

    // Scheduler FSM with registered write-ready, channel walk and channel state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            ch       <= '0;
            wr_ready <= 1'b0;
            settled  <= '1;
            // NOTE: the target/command arrays are plain flops that drive the servos, so they are reset like any control state.
            for (int k = 0; k < NUM_CH; k++) begin
                tgt[k] <= CTR_V;
                cmd[k] <= CTR_V;
            end
        end else begin
            tgt     <= tgt_nxt;
            cmd     <= cmd_nxt;
            settled <= settled_nxt;
            case (state)
                IDLE: begin
                    if (tick && !hold) begin
                        state    <= SCAN;
                        ch       <= '0;
                        wr_ready <= 1'b0;
                    end else begin
                        wr_ready <= 1'b1;
                    end
                end
                SCAN: begin
                    if (ch == CH_W'(NUM_CH - 1)) begin
                        state    <= IDLE;
                        ch       <= '0;
                        wr_ready <= 1'b1;
                    end else begin
                        ch <= ch + CH_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    ch       <= '0;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cmd0 = cmd[0];
    assign cmd1 = cmd[1];
    assign cmd2 = cmd[2];
    assign cmd3 = cmd[3];

endmodule
